// File: rtl/axi_master_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_bridge_pkg
// Description : Shared AXI encodings and FSM state type for the line bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_master_bridge_pkg;

    // AXI AxBURST encodings
    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi_burst_e;

    // AXI xRESP encodings
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    // AxSIZE encoding for 8-byte beats
    localparam logic [2:0] c_SIZE_8B = 3'b011;

    // Bridge FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5,
        S_RESP = 3'd6
    } state_e;

endpackage : axi_master_bridge_pkg
`default_nettype wire

// File: rtl/axi_master_bridge_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : axi_line_buffer
// Description : BURST_LEN x DATA_WIDTH line register file. A whole line can be
//               loaded at once, or a single beat written by index; the beat
//               at the same index is read back combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_line_buffer #(
    parameter int BURST_LEN  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_load,
    input  logic [BURST_LEN*DATA_WIDTH-1:0] i_line,
    input  logic                            i_wr_en,
    input  logic [IDX_W-1:0]                i_idx,
    input  logic [DATA_WIDTH-1:0]           i_wr_data,
    output logic [DATA_WIDTH-1:0]           o_rd_data,
    output logic [BURST_LEN*DATA_WIDTH-1:0] o_line
);

    logic [BURST_LEN*DATA_WIDTH-1:0] w_line;

    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_beat
            logic [DATA_WIDTH-1:0] r_beat_q;
            logic [DATA_WIDTH-1:0] w_beat_d;

            // Next beat value: full-line load wins over an indexed beat write
            always_comb begin
                w_beat_d = r_beat_q;
                if (i_load) begin
                    w_beat_d = i_line[gi*DATA_WIDTH +: DATA_WIDTH];
                end else if (i_wr_en && (i_idx == IDX_W'(gi))) begin
                    w_beat_d = i_wr_data;
                end
            end

            // Beat storage register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_beat_q <= '0;
                end else begin
                    r_beat_q <= w_beat_d;
                end
            end

            assign w_line[gi*DATA_WIDTH +: DATA_WIDTH] = r_beat_q;
        end
    endgenerate

    // Beat read mux
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < BURST_LEN; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_rd_data = w_line[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_line = w_line;

endmodule : axi_line_buffer
`default_nettype wire

// File: rtl/axi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_bridge
// Description : Single-outstanding AXI4 master turning line read/write
//               requests into BURST_LEN-beat INCR bursts of 64-bit beats.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_master_bridge
    import axi_master_bridge_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 4
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    // Request / response side
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [BURST_LEN*DATA_WIDTH-1:0] req_wline,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [BURST_LEN*DATA_WIDTH-1:0] resp_rline,
    output logic                            resp_err,
    // Write address channel
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [ID_WIDTH-1:0]             M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]           M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    // Write data channel
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0]           M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    // Write response channel
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]             M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    // Read address channel
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]             M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0]           M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    // Read data channel
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    input  logic [ID_WIDTH-1:0]             M_AXI_RID,
    input  logic [DATA_WIDTH-1:0]           M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST
);

    localparam int                    c_CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_CNT_W-1:0]    c_LAST_IDX = c_CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK = ADDR_WIDTH'(BURST_LEN * 8 - 1);
    localparam logic [7:0]            c_AXLEN    = 8'(BURST_LEN - 1);

    state_e                  r_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q,  w_addr_d;
    logic [c_CNT_W-1:0]      r_cnt_q,   w_cnt_d;
    logic                    r_err_q,   w_err_d;
    logic                    w_last_beat;
    logic                    w_buf_load;
    logic                    w_buf_wr_en;
    logic [DATA_WIDTH-1:0]   w_buf_rd_data;
    logic                    w_unused_ids;

    // Transaction IDs are not checked: only one burst is ever in flight
    assign w_unused_ids = ^{M_AXI_RID, M_AXI_BID};

    // Next-state, address, beat counter and error accumulation
    always_comb begin
        w_state_d   = r_state_q;
        w_addr_d    = r_addr_q;
        w_cnt_d     = r_cnt_q;
        w_err_d     = r_err_q;
        w_buf_load  = 1'b0;
        w_buf_wr_en = 1'b0;
        w_last_beat = (r_cnt_q == c_LAST_IDX);
        case (r_state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w_addr_d   = req_addr & ~c_OFF_MASK;
                    w_cnt_d    = '0;
                    w_err_d    = 1'b0;
                    w_buf_load = 1'b1;
                    w_state_d  = req_write ? S_AW : S_AR;
                end
            end
            S_AR: begin
                if (M_AXI_ARREADY) w_state_d = S_R;
            end
            S_R: begin
                if (M_AXI_RVALID) begin
                    w_buf_wr_en = 1'b1;
                    if (M_AXI_RRESP != RESP_OKAY) w_err_d = 1'b1;
                    if (w_last_beat) begin
                        // Final beat must carry RLAST
                        if (!M_AXI_RLAST) w_err_d = 1'b1;
                        w_cnt_d   = '0;
                        w_state_d = S_RESP;
                    end else if (M_AXI_RLAST) begin
                        // Short burst: record the error and stop collecting
                        w_err_d   = 1'b1;
                        w_cnt_d   = '0;
                        w_state_d = S_RESP;
                    end else begin
                        w_cnt_d = r_cnt_q + c_CNT_W'(1);
                    end
                end
            end
            S_AW: begin
                if (M_AXI_AWREADY) w_state_d = S_W;
            end
            S_W: begin
                if (M_AXI_WREADY) begin
                    if (w_last_beat) begin
                        w_cnt_d   = '0;
                        w_state_d = S_B;
                    end else begin
                        w_cnt_d = r_cnt_q + c_CNT_W'(1);
                    end
                end
            end
            S_B: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY) w_err_d = 1'b1;
                    w_state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state_q <= S_IDLE;
            r_addr_q  <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_cnt_q   <= w_cnt_d;
            r_err_q   <= w_err_d;
        end
    end

    // Line storage shared by read gather and write stream-out
    axi_line_buffer #(
        .BURST_LEN  (BURST_LEN),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (c_CNT_W)
    ) u_line_buffer (
        .clk       (M_AXI_ACLK),
        .rst       (M_AXI_ARESET),
        .i_load    (w_buf_load),
        .i_line    (req_wline),
        .i_wr_en   (w_buf_wr_en),
        .i_idx     (r_cnt_q),
        .i_wr_data (M_AXI_RDATA),
        .o_rd_data (w_buf_rd_data),
        .o_line    (resp_rline)
    );

    // Handshake outputs decode directly from the registered state
    assign req_ready     = (r_state_q == S_IDLE);
    assign resp_valid    = (r_state_q == S_RESP);
    assign resp_err      = r_err_q;

    assign M_AXI_ARVALID = (r_state_q == S_AR);
    assign M_AXI_ARID    = ID_WIDTH'(AXI_ID);
    assign M_AXI_ARADDR  = r_addr_q;
    assign M_AXI_ARLEN   = c_AXLEN;
    assign M_AXI_ARSIZE  = c_SIZE_8B;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_RREADY  = (r_state_q == S_R);

    assign M_AXI_AWVALID = (r_state_q == S_AW);
    assign M_AXI_AWID    = ID_WIDTH'(AXI_ID);
    assign M_AXI_AWADDR  = r_addr_q;
    assign M_AXI_AWLEN   = c_AXLEN;
    assign M_AXI_AWSIZE  = c_SIZE_8B;
    assign M_AXI_AWBURST = BURST_INCR;

    assign M_AXI_WVALID  = (r_state_q == S_W);
    assign M_AXI_WDATA   = w_buf_rd_data;
    assign M_AXI_WSTRB   = {(DATA_WIDTH/8){1'b1}};
    assign M_AXI_WLAST   = (r_state_q == S_W) && w_last_beat;
    assign M_AXI_BREADY  = (r_state_q == S_B);

endmodule : axi_master_bridge
`default_nettype wire

// File: tb/tb_axi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_master_bridge
// Description : Directed, table-driven bench for axi_master_bridge with a
//               small behavioural AXI slave and hand-written reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_master_bridge;

    localparam int BL = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr;
    logic [255:0] req_wline;
    logic         resp_valid, resp_ready, resp_err;
    logic [255:0] resp_rline;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]   awid, bid, arid, rid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic [63:0]  wdata, rdata;
    logic [7:0]   wstrb;
    logic         arvalid, arready, rvalid, rready, rlast;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    axi_master_bridge dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wline(req_wline),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rline(resp_rline), .resp_err(resp_err),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWID(awid),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BID(bid),
        .M_AXI_BRESP(bresp),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARID(arid),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RID(rid),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast)
    );

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] line;       // request write line
        logic [255:0] rd_line;    // data the slave returns on reads
        int           ax_delay;   // cycles AxREADY stays low
        logic         gap;        // gapped RVALID / toggling WREADY
        int           err_beat;   // read beat carrying RRESP=SLVERR (-1 none)
        int           last_beat;  // read beat carrying RLAST
        logic [1:0]   bresp;
        int           hold;       // cycles resp_ready held low
        logic [31:0]  exp_addr;
        logic         exp_err;
        int           exp_beats;  // read beats expected in resp_rline
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int n, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (vec %0d): got %h required %h", name, n, act, exp);
        end
    endtask

    task automatic clear_slave();
        arready = 0; awready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
        wready = 0; bvalid = 0; bresp = 0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int   phase, beat, dly, cyc;
        logic tgl;
        logic spur_ok;
        @(negedge clk);
        chk("req_ready_idle", n, req_ready, 1);
        req_valid = 1; req_write = v.wr; req_addr = v.addr; req_wline = v.line;
        @(negedge clk);
        req_valid = 0;
        chk("req_ready_drop", n, req_ready, 0);
        phase = 0; beat = 0; dly = 0; cyc = 0; tgl = 0;
        while (!resp_valid && cyc < 300) begin
            clear_slave();
            case (phase)
                0: begin
                    if (v.wr) begin
                        chk("w_before_aw", n, wvalid, 0);
                        chk("awvalid", n, awvalid, 1);
                        chk("awaddr", n, awaddr, v.exp_addr);
                        chk("aw_len_size_burst_id", n, {awlen, awsize, awburst, awid}, {8'd3, 3'd3, 2'd1, 4'd0});
                    end else begin
                        chk("arvalid", n, arvalid, 1);
                        chk("araddr", n, araddr, v.exp_addr);
                        chk("ar_len_size_burst_id", n, {arlen, arsize, arburst, arid}, {8'd3, 3'd3, 2'd1, 4'd0});
                    end
                    if (dly == v.ax_delay) begin
                        if (v.wr) awready = 1; else arready = 1;
                        phase = 1;
                    end else dly++;
                end
                1: begin
                    if (v.wr) begin
                        chk("wvalid", n, wvalid, 1);
                        chk("wdata", n, wdata, v.line[beat*64 +: 64]);
                        chk("wlast_wstrb", n, {wlast, wstrb}, {(beat == BL-1), 8'hFF});
                        wready = v.gap ? tgl : 1'b1;
                        if (wready && wvalid) beat++;
                        if (beat == BL) phase = 2;
                    end else begin
                        chk("rready", n, rready, 1);
                        if (!v.gap || tgl) begin
                            rvalid = 1;
                            rdata  = v.rd_line[beat*64 +: 64];
                            rresp  = (beat == v.err_beat) ? 2'd2 : 2'd0;
                            rlast  = (beat == v.last_beat);
                            if (rready) beat++;
                        end
                        if (beat > v.last_beat || beat == BL) phase = 3;
                    end
                    tgl = ~tgl;
                end
                2: begin
                    chk("no_extra_w", n, wvalid, 0);
                    chk("bready", n, bready, 1);
                    bvalid = 1; bresp = v.bresp;
                    if (bready) phase = 3;
                end
                default: ;
            endcase
            @(negedge clk);
            cyc++;
        end
        clear_slave();
        if (!resp_valid) begin
            failed++; tests++;
            $display("FAIL resp_timeout (vec %0d): got resp_valid=0 required 1", n);
            return;
        end
        chk("resp_err", n, resp_err, v.exp_err);
        if (!v.wr)
            for (int i = 0; i < v.exp_beats; i++)
                chk("resp_rline_beat", n, resp_rline[i*64 +: 64], v.rd_line[i*64 +: 64]);
        // Response hold with a competing request that must be ignored
        spur_ok = 1;
        for (int i = 0; i < v.hold; i++) begin
            req_valid = 1; req_write = ~v.wr; req_addr = 32'h0BAD_0000;
            @(negedge clk);
            chk("hold_resp_valid", n, resp_valid, 1);
            chk("hold_req_ready", n, req_ready, 0);
            chk("hold_resp_err", n, resp_err, v.exp_err);
            if (!v.wr) chk("hold_rline_beat0", n, resp_rline[63:0], v.rd_line[63:0]);
            if (arvalid || awvalid) spur_ok = 0;
        end
        if (v.hold > 0) chk("hold_no_new_burst", n, spur_ok, 1);
        req_valid = 0;
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        chk("back_idle", n, {req_ready, resp_valid}, 2'b10);
    endtask

    localparam logic [255:0] c_RD0 = {64'h44, 64'h33, 64'h22, 64'h11};
    localparam logic [255:0] c_RD1 = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                      64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    localparam logic [255:0] c_WL0 = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                                      64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
    localparam logic [255:0] c_WL1 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'h5555_AAAA_5555_AAAA, 64'hFFFF_0000_FFFF_0000};
    localparam logic [255:0] c_JNK = {4{64'hDEAD_BEEF_CAFE_F00D}};

    initial begin
        //          wr  addr          line   rd_line dly gap eb  lb bresp hold exp_addr      err beats
        vecs[0] = '{1'b0, 32'h8000_0010, c_JNK, c_RD0, 0, 1'b0, -1, 3, 2'd0, 0,  32'h8000_0000, 1'b0, 4};
        vecs[1] = '{1'b1, 32'h8000_0100, c_WL0, c_JNK, 0, 1'b0, -1, 3, 2'd0, 0,  32'h8000_0100, 1'b0, 0};
        vecs[2] = '{1'b0, 32'h1234_5678, c_JNK, c_RD1, 5, 1'b1, -1, 3, 2'd0, 0,  32'h1234_5660, 1'b0, 4};
        vecs[3] = '{1'b1, 32'h0000_003F, c_WL1, c_JNK, 3, 1'b1, -1, 3, 2'd0, 0,  32'h0000_0020, 1'b0, 0};
        vecs[4] = '{1'b0, 32'h4000_0040, c_JNK, c_RD1, 0, 1'b0,  1, 3, 2'd0, 0,  32'h4000_0040, 1'b1, 4};
        vecs[5] = '{1'b0, 32'h4000_0080, c_JNK, c_RD0, 0, 1'b0, -1, 2, 2'd0, 0,  32'h4000_0080, 1'b1, 3};
        vecs[6] = '{1'b1, 32'h4000_00C0, c_WL0, c_JNK, 1, 1'b0, -1, 3, 2'd3, 0,  32'h4000_00C0, 1'b1, 0};
        vecs[7] = '{1'b0, 32'hFFFF_FFE7, c_JNK, c_RD1, 0, 1'b1, -1, 3, 2'd0, 10, 32'hFFFF_FFE0, 1'b0, 4};
        vecs[8] = '{1'b1, 32'h0000_1008, c_WL1, c_JNK, 0, 1'b1, -1, 3, 2'd0, 10, 32'h0000_1000, 1'b0, 0};
        vecs[9] = '{1'b0, 32'h2000_0000, c_JNK, c_RD0, 0, 1'b0, -1, 4, 2'd0, 0,  32'h2000_0000, 1'b1, 4};

        rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wline = '0; resp_ready = 0;
        rid = 4'd5; bid = 4'd9;
        clear_slave();
        repeat (3) @(negedge clk);
        chk("rst_valids", -1, {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 6'b0);
        chk("rst_req_ready", -1, req_ready, 1);
        chk("rst_resp", -1, {resp_err, resp_rline}, '0);
        rst = 0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset while the third write beat is on the bus
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h0000_0100; req_wline = c_WL0;
        @(negedge clk);
        req_valid = 0;
        awready = 1;
        @(negedge clk);
        awready = 0; wready = 1;
        repeat (2) @(negedge clk);
        wready = 0;
        chk("mid_w_beat2", 100, wdata, c_WL0[191:128]);
        rst = 1;
        @(negedge clk);
        chk("midrst_valids", 100, {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 6'b0);
        chk("midrst_req_ready", 100, req_ready, 1);
        chk("midrst_resp", 100, {resp_err, resp_rline}, '0);
        rst = 0;
        run_vec(vecs[0], 101);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_axi_master_bridge
`default_nettype wire

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Single-outstanding AXI4 master that turns line-granular read/write requests from the cache/LSU side into AXI4 INCR bursts toward memory-side slaves such as the DPI-backed AXI slave memory.
- A read gathers BURST_LEN 64-bit beats into a line buffer. A write streams a latched line out as BURST_LEN beats.
- Sits between the core's memory stage/cache and the AXI interconnect.

Parameters:
- ID_WIDTH, 4, AXI ID width; ARID/AWID driven constant from AXI_ID.
- AXI_ID, 0, ID value placed on ARID/AWID.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width. Only 64 is supported.
- BURST_LEN, 4, beats per line, power of two in 1..16.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESET  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  bridge idle, accepts request
- req_write  in  1  1=write line, 0=read line
- req_addr  in  ADDR_WIDTH  line address; low log2(BURST_LEN*8) bits forced to 0
- req_wline  in  BURST_LEN*64  write line; beat i = bits [i*64+63:i*64]
- resp_valid  out  1  completion valid, held until resp_ready
- resp_ready  in  1  completion accepted
- resp_rline  out  BURST_LEN*64  read line (valid when resp_valid after read)
- resp_err  out  1  any non-OKAY response or RLAST protocol error
- M_AXI_AWVALID/AWREADY/AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out/in/out/out/out/out/out  1/1/ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel
- M_AXI_WVALID/WREADY/WDATA/WSTRB/WLAST  out/in/out/out/out  1/1/64/8/1  write data channel
- M_AXI_BVALID/BREADY/BID/BRESP  in/out/in/in  1/1/ID_WIDTH/2  write response channel
- M_AXI_ARVALID/ARREADY/ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out/in/out/out/out/out/out  1/1/ID_WIDTH/ADDR_WIDTH/8/3/2  read address channel
- M_AXI_RVALID/RREADY/RID/RDATA/RRESP/RLAST  in/out/in/in/in/in  1/1/ID_WIDTH/64/2/1  read data channel

Behaviour:
- Reset: FSM=IDLE. All VALID/READY outputs 0, except req_ready=1. resp_valid=0, resp_err=0, resp_rline=0, beat counter=0. Reset mid-burst abandons the transaction at the next edge; the slave shares the reset.
- Constant outputs: AxLEN=BURST_LEN-1, AxSIZE=3'b011, AxBURST=2'b01 (INCR), AxID=AXI_ID, WSTRB=8'hFF.
- States: IDLE, AR, R, AW, W, B, RESP.
- IDLE: req_ready=1. On req_valid, latch aligned address, req_write and req_wline; clear err and counter; go to AR (read) or AW (write). req_ready drops the cycle after acceptance.
- AR: ARVALID=1 with latched address. Hold VALID and all payload stable until ARREADY. On the handshake go to R.
- R: RREADY=1. On each RVALID&RREADY, store RDATA into beat[cnt] and increment cnt.
  - RRESP!=0 sets err.
  - RLAST on cnt<BURST_LEN-1 sets err and ends the burst.
  - On the final beat (cnt==BURST_LEN-1), RLAST must be 1, otherwise set err. Go to RESP.
- AW: AWVALID=1 until AWREADY, then go to W. WVALID is never asserted before the AW handshake completes.
- W: WVALID=1, WDATA=beat[cnt], WLAST=(cnt==BURST_LEN-1). Advance cnt on WVALID&WREADY. Payload is stable while WREADY=0. After the last beat go to B.
- B: BREADY=1. On BVALID, BRESP!=0 sets err. Go to RESP.
- RESP: resp_valid=1. resp_rline and resp_err are stable. On resp_ready go to IDLE the next cycle.
- Throughput: at most one beat per cycle. Single outstanding transaction. No read/write overlap.
- Boundaries:
  - BURST_LEN=1 means AxLEN=0 and WLAST on the first beat.
  - A READY asserted in the same cycle VALID rises completes that cycle.
  - RID/BID mismatch is ignored.
  - The counter never exceeds BURST_LEN-1.

Decomposition:
- Shared package holds:
  - AXI burst-type constants (FIXED=0, INCR=1, WRAP=2);
  - response codes (OKAY=0, SLVERR=2, DECERR=3);
  - the SIZE encoding for 8 bytes;
  - the FSM state enum.
- Optional sub-module axi_line_buffer: a BURST_LEN×64 register file with beat-indexed write/read. The FSM stays in the top module.

Test Plan:
- Read, BURST_LEN=4, req_addr=0x8000_0010:
  - required: ARADDR=0x8000_0000, ARLEN=3;
  - slave returns beats 0x11,0x22,0x33,0x44 with RLAST on the 4th -> resp_rline={0x44,0x33,0x22,0x11}, resp_err=0.
- Write to 0x8000_0100, line {D3,D2,D1,D0}:
  - required: AW completes before the first WVALID; WDATA D0..D3, WLAST only on D3, WSTRB=FF;
  - BRESP=0 -> resp_valid with resp_err=0.
- Backpressure: ARREADY delayed 5 cycles, RVALID gapped every other cycle, WREADY toggling -> payloads stable while stalled, exact beat order preserved, no extra beats.
- Errors:
  - RRESP=2 on beat 1 -> resp_err=1;
  - RLAST early on beat 2 -> burst ends, resp_err=1;
  - BRESP=3 -> resp_err=1.
- Response hold: resp_ready held 0 for 10 cycles -> resp_valid and data stable, req_ready=0, a new req_valid is ignored until the handshake.
- Reset asserted mid-W beat 2 -> the next cycle all VALIDs=0, req_ready=1; a new read after reset completes correctly.
